// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM request controller.
package ram_ctrl_pkg;

   // Default geometry of the attached RAM (4 words of 5 bits).
   localparam int DW_DEF = 5;
   localparam int AW_DEF = 2;

   // RAM strobe encodings: enable and write are both active-low.
   localparam logic EN_ACTIVE = 1'b0;
   localparam logic EN_IDLE   = 1'b1;
   localparam logic OP_WRITE  = 1'b0;
   localparam logic OP_READ   = 1'b1;

   // Controller states.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      CAPT = 3'd2,
      RESP = 3'd3,
      INIT = 3'd4
   } state_t;

endpackage : ram_ctrl_pkg

// File: rtl/ram_ctrl.sv
// Request-side controller for a single-port synchronous RAM: accepts
// read/write requests on a valid/ready channel, drives registered RAM
// strobes, returns read data on a valid/ready response channel, and can
// sweep INIT_VAL into every location on request.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int            DW       = DW_DEF,
   parameter int            AW       = AW_DEF,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   // request channel
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   // response channel
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   // init sweep
   input  logic          init_start,
   output logic          init_busy,
   // RAM side
   output logic          ram_en,
   output logic          ram_wr,
   output logic [AW-1:0] ram_add,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data
);

   localparam int            DEPTH     = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state_q,      state_d;
   logic          ram_en_q,     ram_en_d;
   logic          ram_wr_q,     ram_wr_d;
   logic [AW-1:0] ram_add_q,    ram_add_d;
   logic [DW-1:0] ram_w_data_q, ram_w_data_d;
   logic          rsp_valid_q,  rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q,  rsp_rdata_d;
   logic          init_busy_q,  init_busy_d;

   // init_start wins over a request in IDLE, so it also masks ready.
   assign req_ready = (state_q == IDLE) && !init_start && !rst;

   // Next-state and next-output logic for every registered signal.
   always_comb begin
      // NOTE: every signal gets a hold default first so no path through the
      // case leaves it unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      ram_en_d     = ram_en_q;
      ram_wr_d     = ram_wr_q;
      ram_add_d    = ram_add_q;
      ram_w_data_d = ram_w_data_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      init_busy_d  = init_busy_q;

      unique case (state_q)
         IDLE: begin
            if (init_start) begin
               state_d      = INIT;
               ram_en_d     = EN_ACTIVE;
               ram_wr_d     = OP_WRITE;
               ram_add_d    = '0;
               ram_w_data_d = INIT_VAL;
               init_busy_d  = 1'b1;
            end else if (req_valid && req_ready) begin
               state_d      = CMD;
               ram_en_d     = EN_ACTIVE;
               ram_wr_d     = req_wr ? OP_WRITE : OP_READ;
               ram_add_d    = req_addr;
               ram_w_data_d = req_wdata;
            end
         end
         CMD: begin
            // The RAM executes the command on this edge; drop the enable.
            ram_en_d = EN_IDLE;
            state_d  = (ram_wr_q == OP_WRITE) ? IDLE : CAPT;
         end
         CAPT: begin
            rsp_rdata_d = ram_r_data;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         INIT: begin
            // Address wraps to 0 as the last location is written.
            ram_add_d = ram_add_q + 1'b1;
            if (ram_add_q == LAST_ADDR) begin
               ram_en_d    = EN_IDLE;
               init_busy_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            ram_en_d = EN_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= IDLE;
         ram_en_q     <= EN_IDLE;
         ram_wr_q     <= OP_READ;
         ram_add_q    <= '0;
         ram_w_data_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         init_busy_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ram_en_q     <= ram_en_d;
         ram_wr_q     <= ram_wr_d;
         ram_add_q    <= ram_add_d;
         ram_w_data_q <= ram_w_data_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         init_busy_q  <= init_busy_d;
      end
   end

   assign ram_en     = ram_en_q;
   assign ram_wr     = ram_wr_q;
   assign ram_add    = ram_add_q;
   assign ram_w_data = ram_w_data_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign init_busy  = init_busy_q;

endmodule : ram_ctrl
